// File: rtl/ifu_bpu_if.sv
// Decode, branch-resolution and prediction signals between the mini-decoder, EXU, regfile and ifu_bpu.
// Latency: none, this is a bundle of wires.
// Backpressure: bpu_wait holds the decoder; master = decoder/EXU/regfile side, slave = predictor.
interface ifu_bpu_if #(
   parameter int PC_SIZE     = 32,
   parameter int XLEN        = 32,
   parameter int RFIDX_WIDTH = 5
);
   logic [PC_SIZE-1:0]     pc;
   logic                   dec_i_valid;
   logic                   dec_jal;
   logic                   dec_jalr;
   logic                   dec_bxx;
   logic [XLEN-1:0]        dec_bjp_imm;
   logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx;
   logic [RFIDX_WIDTH-1:0] dec_rdidx;
   logic                   dep_x1;
   logic                   dep_rs1;
   logic                   ir_valid_clr;
   logic [XLEN-1:0]        rf2bpu_x1;
   logic [XLEN-1:0]        rf2bpu_rs1;
   logic                   upd_valid;
   logic [PC_SIZE-1:0]     upd_pc;
   logic                   upd_taken;
   logic                   bpu_wait;
   logic                   bpu2rf_rs1_ena;
   logic                   prdt_taken;
   logic [PC_SIZE-1:0]     prdt_pc_add_op1;
   logic [PC_SIZE-1:0]     prdt_pc_add_op2;

   modport master (
      output pc, dec_i_valid, dec_jal, dec_jalr, dec_bxx, dec_bjp_imm, dec_jalr_rs1idx, dec_rdidx,
             dep_x1, dep_rs1, ir_valid_clr, rf2bpu_x1, rf2bpu_rs1, upd_valid, upd_pc, upd_taken,
      input  bpu_wait, bpu2rf_rs1_ena, prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2
   );

   modport slave (
      input  pc, dec_i_valid, dec_jal, dec_jalr, dec_bxx, dec_bjp_imm, dec_jalr_rs1idx, dec_rdidx,
             dep_x1, dep_rs1, ir_valid_clr, rf2bpu_x1, rf2bpu_rs1, upd_valid, upd_pc, upd_taken,
      output bpu_wait, bpu2rf_rs1_ena, prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2
   );
endinterface

// File: rtl/ifu_bpu.sv
// IFU branch predictor: BHT of 2-bit counters, return address stack, JALR rs1 read sequencer.
// Latency: prediction and adder operands are combinational (0 cycles); rsN JALR costs 1 stall cycle.
// Backpressure: bpu_wait holds the decoded instruction while x1/rs1 are not yet readable.
// Ports: clk, rst (async, active-low), bus (slave side of ifu_bpu_if): decode inputs, dependency
//        flags, regfile read values, EXU update strobe; outputs bpu_wait, bpu2rf_rs1_ena,
//        prdt_taken and the two target adder operands.
module ifu_bpu #(
   parameter int PC_SIZE     = 32,
   parameter int XLEN        = 32,
   parameter int RFIDX_WIDTH = 5,
   parameter int BHT_DEPTH   = 16,
   parameter int RAS_DEPTH   = 4
) (
   input logic      clk,
   input logic      rst,
   ifu_bpu_if.slave bus
);
   localparam int BHT_IW = $clog2(BHT_DEPTH);
   localparam int RAS_PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int RAS_CW = $clog2(RAS_DEPTH + 1);

   typedef enum logic {IDLE, RDRF} state_t;

   state_t             state;
   logic [1:0]         bht [BHT_DEPTH];
   logic [PC_SIZE-1:0] ras [RAS_DEPTH];
   logic [RAS_PW-1:0]  ras_ptr;   // next free slot; top lives at ras_ptr-1
   logic [RAS_CW-1:0]  ras_cnt;

   logic [BHT_IW-1:0]  prd_idx, upd_idx;
   logic [RAS_PW-1:0]  ras_top, ras_ptr_inc;
   logic               rs1_x0, rs1_x1, rs1_link, rd_link;
   logic               pop_cond, ras_hit, rsn_path, x1_wait, rd_grant;
   logic               rd_ena, stall, fire, push, pop;
   logic [PC_SIZE-1:0] push_val, op1;
   logic               unused_upd_pc;

   assign prd_idx = bus.pc[BHT_IW+1:2];
   assign upd_idx = bus.upd_pc[BHT_IW+1:2];
   assign unused_upd_pc = ^bus.upd_pc;

   assign rs1_x0   = (bus.dec_jalr_rs1idx == '0);
   assign rs1_x1   = (bus.dec_jalr_rs1idx == RFIDX_WIDTH'(1));
   assign rs1_link = rs1_x1 | (bus.dec_jalr_rs1idx == RFIDX_WIDTH'(5));
   assign rd_link  = (bus.dec_rdidx == RFIDX_WIDTH'(1)) | (bus.dec_rdidx == RFIDX_WIDTH'(5));

   // A link-to-link JALR with rd==rs1 is a coroutine swap, not a return: it must not pop.
   assign pop_cond = bus.dec_jalr & rs1_link & ~(rd_link & (bus.dec_rdidx == bus.dec_jalr_rs1idx));
   assign ras_hit  = pop_cond & (ras_cnt != '0);
   assign rsn_path = bus.dec_jalr & ~rs1_x0 & ~rs1_x1 & ~ras_hit;
   assign x1_wait  = bus.dec_jalr & rs1_x1 & ~ras_hit & bus.dep_x1;
   assign rd_grant = ~bus.dep_rs1 | bus.ir_valid_clr;

   // The read request is gated by reset so it drops in the very cycle reset asserts,
   // even though the decoder may still be presenting the JALR.
   assign rd_ena = rst & (state == IDLE) & bus.dec_i_valid & rsn_path & rd_grant;
   // In RDRF the regfile value is on rf2bpu_rs1, so the held JALR is accepted.
   assign stall  = bus.dec_i_valid & (x1_wait | ((state == IDLE) & rsn_path));
   assign fire   = bus.dec_i_valid & ~stall;

   assign push     = fire & (bus.dec_jal | bus.dec_jalr) & rd_link;
   assign pop      = fire & ras_hit;
   assign push_val = bus.pc + PC_SIZE'(4);

   assign ras_top     = (ras_ptr == '0) ? RAS_PW'(RAS_DEPTH - 1) : ras_ptr - 1'b1;
   assign ras_ptr_inc = (ras_ptr == RAS_PW'(RAS_DEPTH - 1)) ? '0 : ras_ptr + 1'b1;

   always_comb begin
      op1 = bus.pc;
      if (bus.dec_jal | bus.dec_bxx)
         op1 = bus.pc;
      else if (bus.dec_jalr & rs1_x0)
         op1 = '0;
      else if (ras_hit)
         op1 = ras[ras_top];
      else if (bus.dec_jalr & rs1_x1)
         op1 = bus.rf2bpu_x1[PC_SIZE-1:0];
      else
         op1 = bus.rf2bpu_rs1[PC_SIZE-1:0];
   end

   assign bus.bpu_wait        = stall;
   assign bus.bpu2rf_rs1_ena  = rd_ena;
   assign bus.prdt_taken      = bus.dec_i_valid &
                                (bus.dec_jal | bus.dec_jalr | (bus.dec_bxx & bht[prd_idx][1]));
   assign bus.prdt_pc_add_op1 = op1;
   assign bus.prdt_pc_add_op2 = bus.dec_bjp_imm[PC_SIZE-1:0];

   // JALR rs1 read sequencer: one cycle to request the port, one cycle to consume the data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (rd_ena) state <= RDRF;
            RDRF: state <= IDLE;
         endcase
      end
   end

   // Return address stack: circular, overwrites the oldest entry when full.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ras_ptr <= '0;
         ras_cnt <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
      end else if (push & pop) begin
         ras[ras_top] <= push_val;
      end else if (push) begin
         ras[ras_ptr] <= push_val;
         ras_ptr      <= ras_ptr_inc;
         if (ras_cnt != RAS_CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
      end else if (pop) begin
         ras_ptr <= ras_top;
         ras_cnt <= ras_cnt - 1'b1;
      end
   end

   // BHT: reads are combinational from the array, so a same-cycle update is seen next cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
      end else if (bus.upd_valid) begin
         if (bus.upd_taken) begin
            if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'b01;
         end else begin
            if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'b01;
         end
      end
   end
endmodule

// File: tb/tb_ifu_bpu.sv
// Testbench for ifu_bpu: directed scenarios plus randomized instruction streams.
// Expected outputs come from a behavioural model (queue RAS, integer BHT) pushed to a scoreboard.
// A negedge monitor pops one expectation per cycle and compares it with the DUT outputs.
module tb_ifu_bpu;
   localparam int PC_SIZE     = 32;
   localparam int XLEN        = 32;
   localparam int RFIDX_WIDTH = 5;
   localparam int BHT_DEPTH   = 16;
   localparam int RAS_DEPTH   = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ifu_bpu_if #(.PC_SIZE(PC_SIZE), .XLEN(XLEN), .RFIDX_WIDTH(RFIDX_WIDTH)) bus ();

   ifu_bpu #(
      .PC_SIZE(PC_SIZE), .XLEN(XLEN), .RFIDX_WIDTH(RFIDX_WIDTH),
      .BHT_DEPTH(BHT_DEPTH), .RAS_DEPTH(RAS_DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      bit          full;    // 0: only the read-enable is defined (instruction held across reset)
      bit          chk_op;
      logic        taken;
      logic        wt;
      logic        ena;
      logic [31:0] op1;
      logic [31:0] op2;
   } exp_t;

   exp_t        exp_q [$];
   int          errors = 0;
   int          checks = 0;
   bit          active = 0;

   // Reference model state
   int          bht_m [BHT_DEPTH];
   logic [31:0] ras_m [$];
   bit          rd_issued;   // regfile read already requested for the held JALR

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
      end
   endtask

   function automatic bit is_link(logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < BHT_DEPTH; i++) bht_m[i] = 1;
      ras_m.delete();
      rd_issued = 0;
   endtask

   // Compute the expected outputs for the inputs currently applied, then advance the model
   // to the state it holds after the next rising edge.
   task automatic expect_cycle(output bit fired);
      exp_t        e;
      bit          jal, jalr, bxx, hit, rsn, stall, ena, push;
      logic [4:0]  rd, rs1;
      logic [31:0] pc;
      int          idx;
      fired    = 0;
      e.full   = 1; e.chk_op = 0; e.taken = 0; e.wt = 0; e.ena = 0; e.op1 = '0; e.op2 = '0;
      if (!rst) begin
         e.full = !bus.dec_i_valid;
         exp_q.push_back(e);
         model_reset();
         return;
      end
      jal  = bus.dec_i_valid && bus.dec_jal;
      jalr = bus.dec_i_valid && bus.dec_jalr;
      bxx  = bus.dec_i_valid && bus.dec_bxx;
      rd   = bus.dec_rdidx;
      rs1  = bus.dec_jalr_rs1idx;
      pc   = bus.pc;
      idx  = int'((pc >> 2) % BHT_DEPTH);
      hit  = jalr && is_link(rs1) && !(is_link(rd) && rd == rs1) && ras_m.size() > 0;
      rsn  = jalr && rs1 != 5'd0 && rs1 != 5'd1 && !hit;
      stall = (jalr && rs1 == 5'd1 && !hit && bus.dep_x1) || (rsn && !rd_issued);
      ena  = rsn && !rd_issued && (!bus.dep_rs1 || bus.ir_valid_clr);
      e.taken  = jal || jalr || (bxx && bht_m[idx] >= 2);
      e.wt     = stall;
      e.ena    = ena;
      e.chk_op = jal || jalr || bxx;
      e.op2    = bus.dec_bjp_imm;
      if (jal || bxx)      e.op1 = pc;
      else if (rs1 == 0)   e.op1 = '0;
      else if (hit)        e.op1 = ras_m[$];
      else if (rs1 == 1)   e.op1 = bus.rf2bpu_x1;
      else                 e.op1 = bus.rf2bpu_rs1;
      exp_q.push_back(e);

      rd_issued = ena;
      fired = bus.dec_i_valid && !stall;
      if (fired) begin
         push = (jal || jalr) && is_link(rd);
         if (push && hit) begin
            ras_m[$] = pc + 32'd4;
         end else if (push) begin
            ras_m.push_back(pc + 32'd4);
            if (ras_m.size() > RAS_DEPTH) void'(ras_m.pop_front());
         end else if (hit) begin
            void'(ras_m.pop_back());
         end
      end
      if (bus.upd_valid) begin
         idx = int'((bus.upd_pc >> 2) % BHT_DEPTH);
         if (bus.upd_taken && bht_m[idx] < 3) bht_m[idx]++;
         else if (!bus.upd_taken && bht_m[idx] > 0) bht_m[idx]--;
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (active) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL queue_underflow at %0t: no expectation for this cycle", $time);
         end else begin
            e = exp_q.pop_front();
            chk("rs1_ena", {31'd0, bus.bpu2rf_rs1_ena}, {31'd0, e.ena});
            if (e.full) begin
               chk("bpu_wait", {31'd0, bus.bpu_wait}, {31'd0, e.wt});
               chk("prdt_taken", {31'd0, bus.prdt_taken}, {31'd0, e.taken});
            end
            if (e.full && e.chk_op) begin
               chk("op1", bus.prdt_pc_add_op1, e.op1);
               chk("op2", bus.prdt_pc_add_op2, e.op2);
            end
         end
      end
   end

   task automatic at_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus.dec_i_valid = 0; bus.dec_jal = 0; bus.dec_jalr = 0; bus.dec_bxx = 0;
      bus.dep_x1 = 0; bus.dep_rs1 = 0; bus.ir_valid_clr = 0; bus.upd_valid = 0;
   endtask

   // kind: 0 = other instruction, 1 = JAL, 2 = JALR, 3 = conditional branch
   task automatic set_ins(int kind, logic [31:0] pc, logic [4:0] rd, logic [4:0] rs1, logic [31:0] imm);
      bus.dec_i_valid     = 1;
      bus.dec_jal         = (kind == 1);
      bus.dec_jalr        = (kind == 2);
      bus.dec_bxx         = (kind == 3);
      bus.pc              = pc;
      bus.dec_rdidx       = rd;
      bus.dec_jalr_rs1idx = rs1;
      bus.dec_bjp_imm     = imm;
   endtask

   task automatic rand_side(bit allow_dep);
      bus.rf2bpu_x1    = $urandom();
      bus.rf2bpu_rs1   = $urandom();
      bus.dep_x1       = allow_dep ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.dep_rs1      = allow_dep ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.ir_valid_clr = ($urandom_range(0, 3) == 0);
      bus.upd_valid    = ($urandom_range(0, 2) == 0);
      bus.upd_pc       = 32'h1000 + 32'($urandom_range(0, 63)) * 32'd4;
      bus.upd_taken    = 1'($urandom_range(0, 1));
   endtask

   // Present one instruction with no dependencies until it is accepted (at most 2 cycles).
   task automatic run_ins(int kind, logic [31:0] pc, logic [4:0] rd, logic [4:0] rs1, logic [31:0] imm);
      bit f;
      int n;
      n = 0;
      do begin
         at_edge();
         set_idle();
         set_ins(kind, pc, rd, rs1, imm);
         bus.rf2bpu_x1  = $urandom();
         bus.rf2bpu_rs1 = $urandom();
         expect_cycle(f);
         n++;
      end while (!f && n < 10);
   endtask

   task automatic upd_cycle(logic [31:0] p, bit t);
      bit f;
      at_edge();
      set_idle();
      bus.upd_valid = 1; bus.upd_pc = p; bus.upd_taken = t;
      expect_cycle(f);
   endtask

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 5))
         0:       return 5'd0;
         1, 4:    return 5'd1;
         2, 5:    return 5'd5;
         default: return 5'd7;
      endcase
   endfunction

   initial begin : stim
      bit f;
      set_idle();
      bus.pc = '0; bus.dec_bjp_imm = '0; bus.dec_rdidx = '0; bus.dec_jalr_rs1idx = '0;
      bus.rf2bpu_x1 = '0; bus.rf2bpu_rs1 = '0; bus.upd_pc = '0; bus.upd_taken = 0;
      model_reset();

      // Reset state
      at_edge(); active = 1; expect_cycle(f);
      at_edge(); expect_cycle(f);
      at_edge(); rst = 1; expect_cycle(f);

      // Weakly-not-taken branch, trained to taken by two updates
      run_ins(3, 32'h8000_0010, 5'd0, 5'd0, 32'hFFFF_FFF8);
      upd_cycle(32'h8000_0010, 1);
      upd_cycle(32'h8000_0010, 1);
      run_ins(3, 32'h8000_0010, 5'd0, 5'd0, 32'hFFFF_FFF8);

      // Call then return through the RAS, then the RAS is empty again
      run_ins(1, 32'h0000_0100, 5'd1, 5'd0, 32'h40);
      run_ins(2, 32'h0000_0200, 5'd0, 5'd1, 32'h0);
      run_ins(2, 32'h0000_0204, 5'd0, 5'd1, 32'h8);
      // Return address wraps at the top of the address space
      run_ins(1, 32'hFFFF_FFFC, 5'd1, 5'd0, 32'h10);
      run_ins(2, 32'h0000_0300, 5'd0, 5'd1, 32'h0);

      // Overflow: five calls, five returns, last one falls back to x1
      for (int i = 0; i < 5; i++) run_ins(1, 32'(i * 16), 5'd1, 5'd0, 32'h20);
      for (int i = 0; i < 5; i++) run_ins(2, 32'h0000_0400, 5'd0, 5'd1, 32'h0);

      // Simultaneous pop and push (JALR rs1=x1 rd=x5), then return through x5
      run_ins(1, 32'h0000_0500, 5'd1, 5'd0, 32'h4);
      run_ins(2, 32'h0000_0600, 5'd5, 5'd1, 32'h0);
      run_ins(2, 32'h0000_0700, 5'd0, 5'd5, 32'h0);

      // JALR x7 blocked by an in-flight rs1 write for 3 cycles, then read, then accepted
      for (int k = 0; k < 4; k++) begin
         at_edge(); set_idle(); set_ins(2, 32'h0000_0800, 5'd0, 5'd7, 32'h14);
         bus.dep_rs1 = (k < 3); bus.rf2bpu_rs1 = $urandom(); bus.rf2bpu_x1 = $urandom();
         expect_cycle(f);
      end
      at_edge(); set_idle(); set_ins(2, 32'h0000_0800, 5'd0, 5'd7, 32'h14);
      bus.rf2bpu_rs1 = 32'h1234_5678; expect_cycle(f);

      // Same-cycle update and read of one BHT entry, then saturation at 3
      at_edge(); set_idle(); set_ins(3, 32'h0000_0920, 5'd0, 5'd0, 32'h30);
      bus.upd_valid = 1; bus.upd_pc = 32'h0000_0920; bus.upd_taken = 1;
      expect_cycle(f);
      run_ins(3, 32'h0000_0920, 5'd0, 5'd0, 32'h30);
      for (int k = 0; k < 4; k++) upd_cycle(32'h0000_0920, 1);
      upd_cycle(32'h0000_0920, 0);
      run_ins(3, 32'h0000_0920, 5'd0, 5'd0, 32'h30);
      upd_cycle(32'h0000_0920, 0);
      run_ins(3, 32'h0000_0920, 5'd0, 5'd0, 32'h30);

      // Randomized instruction streams with random dependencies and updates
      for (int n = 0; n < 600; n++) begin
         int          kind, stalls;
         logic [31:0] pc, imm;
         logic [4:0]  rd, rs1;
         kind = $urandom_range(0, 3);
         pc   = 32'h1000 + 32'($urandom_range(0, 63)) * 32'd4;
         imm  = $urandom();
         rd   = pick_reg();
         rs1  = pick_reg();
         if ($urandom_range(0, 3) == 0) begin
            at_edge(); set_idle(); rand_side(1); bus.dep_x1 = 0; bus.dep_rs1 = 0; expect_cycle(f);
         end
         stalls = 0;
         do begin
            at_edge();
            set_ins(kind, pc, rd, rs1, imm);
            rand_side(stalls < 6);
            expect_cycle(f);
            stalls++;
         end while (!f && stalls < 20);
      end

      // Reset asserted while the rs1 read is in progress
      for (int k = 0; k < 3; k++) upd_cycle(32'h0000_0A00, 1);
      run_ins(3, 32'h0000_0A00, 5'd0, 5'd0, 32'h8);
      run_ins(1, 32'h0000_0B00, 5'd1, 5'd0, 32'h8);
      at_edge(); set_idle(); set_ins(2, 32'h0000_0C00, 5'd0, 5'd7, 32'h0); expect_cycle(f);
      at_edge(); set_idle(); set_ins(2, 32'h0000_0C00, 5'd0, 5'd7, 32'h0);
      #1 rst = 0;
      expect_cycle(f);
      at_edge(); set_idle(); expect_cycle(f);
      at_edge(); rst = 1; expect_cycle(f);
      run_ins(3, 32'h0000_0A00, 5'd0, 5'd0, 32'h8);
      run_ins(2, 32'h0000_0D00, 5'd0, 5'd1, 32'h0);

      at_edge();
      active = 0;
      set_idle();
      chk("queue_drain", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
